// File: rtl/rst_release_seq.sv
// Debounced release button driving an ordered, masked release of NUM_CH active-low resets.
// Kill (or, in follow mode, a debounced button fall) re-asserts every reset at once.
module rst_release_seq #(
    parameter int NUM_CH    = 4,
    parameter int DB_CYCLES = 1000,
    parameter int STAGE_GAP = 16,
    parameter int MODE      = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill_i,
    input  logic              button_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    output logic [NUM_CH-1:0] rstn_o,
    output logic              btn_level_o,
    output logic              btn_rflag_o,
    output logic              btn_fflag_o,
    output logic              seq_busy_o,
    output logic              seq_done_o
);

    // state | meaning
    // IDLE  | all resets asserted, waiting for a debounced rise
    // STEP  | releasing enabled channels one gap apart
    // DONE  | sequence finished, released channels held open
    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    localparam int MAX_CNT = (DB_CYCLES > STAGE_GAP) ? DB_CYCLES : STAGE_GAP;

    if ((64'd1 << CNT_W) <= 64'(MAX_CNT)) begin : g_cnt_w_err
        $error("rst_release_seq: CNT_W too small for DB_CYCLES/STAGE_GAP");
    end
    if (NUM_CH < 1 || NUM_CH > 16 || DB_CYCLES < 2 || STAGE_GAP < 1) begin : g_param_err
        $error("rst_release_seq: parameter out of range");
    end

    logic             sync1_q, sync_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             rflag_q, rflag_d;
    logic             fflag_q, fflag_d;

    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        rflag_d  = 1'b0;
        fflag_d  = 1'b0;
        if (sync_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            db_cnt_d = '0;
            level_d  = ~level_q;
            rflag_d  = ~level_q;
            fflag_d  = level_q;
        end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            rflag_q  <= 1'b0;
            fflag_q  <= 1'b0;
        end else begin
            sync1_q  <= button_i;
            sync_q   <= sync1_q;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            rflag_q  <= rflag_d;
            fflag_q  <= fflag_d;
        end
    end

    state_t            state_q;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] rstn_q;
    logic [CNT_W-1:0]  gap_q;
    logic              busy_q, done_q;
    logic [NUM_CH-1:0] first_bit, next_bit;
    logic              abort;

    // en_q holds the channels still waiting for release; its lowest set bit goes next
    assign first_bit = ch_en_i & (~ch_en_i + NUM_CH'(1));
    assign next_bit  = en_q & (~en_q + NUM_CH'(1));
    assign abort     = kill_i | ((MODE == 1) & fflag_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= '0;
            rstn_q  <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
            en_q    <= '0;
            rstn_q  <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rflag_q) begin
                        rstn_q <= first_bit;
                        en_q   <= ch_en_i & ~first_bit;
                        gap_q  <= CNT_W'(STAGE_GAP - 1);
                        if ((ch_en_i & ~first_bit) == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= STEP;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (gap_q == '0) begin
                        rstn_q <= rstn_q | next_bit;
                        en_q   <= en_q & ~next_bit;
                        gap_q  <= CNT_W'(STAGE_GAP - 1);
                        if ((en_q & ~next_bit) == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        gap_q <= gap_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rstn_o      = rstn_q;
    assign btn_level_o = level_q;
    assign btn_rflag_o = rflag_q;
    assign btn_fflag_o = fflag_q;
    assign seq_busy_o  = busy_q;
    assign seq_done_o  = done_q;

endmodule
